div_share_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined divider between up to `N_REQ` requesters, such as the bottom-ROI centroid tracker and additional ROI or vertical-centroid trackers. It sits between the requesters and the single divider instance. The block does the following:
- accepts at most one division per cycle;
- registers the operands into the divider;
- tracks each in-flight operation with a tag shift register;
- routes each quotient back to its originator as a one-cycle pulse.

---
 rtl/div_share_arbiter.sv | 125 ++++++++++++
 tb/tb_div_share_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
`default_nettype none
// ============================================================================
// div_share_arbiter : round-robin sharing of one pipelined divider among
//                     N_REQ requesters, with tagged in-order result return.
// Revision 1.0
// ============================================================================
module div_share_arbiter #(
    parameter int N_REQ       = 2,
    parameter int NUMER_W     = 24,
    parameter int DENOM_W     = 16,
    parameter int DIV_LATENCY = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*NUMER_W-1:0]   req_numer,
    input  logic [N_REQ*DENOM_W-1:0]   req_denom,
    output logic [N_REQ-1:0]           req_ready,
    output logic [NUMER_W-1:0]         div_numer,
    output logic [DENOM_W-1:0]         div_denom,
    input  logic [NUMER_W-1:0]         div_quotient,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [NUMER_W-1:0]         resp_quotient,
    output logic                       resp_dbz,
    output logic                       busy
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAST = DIV_LATENCY - 1;

    logic [ID_W-1:0]    last_grant;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               transfer;
    logic [NUMER_W-1:0] sel_numer;
    logic [DENOM_W-1:0] sel_denom;
    int                 idx;

    logic               op_valid;
    logic [ID_W-1:0]    op_id;
    logic               op_dbz;

    logic [DIV_LATENCY-1:0] tag_valid;
    logic [DIV_LATENCY-1:0] tag_dbz;
    logic [ID_W-1:0]        tag_id [DIV_LATENCY];

    // First pending requester found scanning upward from last_grant+1
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        transfer  = 1'b0;
        sel_numer = '0;
        sel_denom = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!transfer && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                transfer   = 1'b1;
                sel_numer  = req_numer[idx*NUMER_W +: NUMER_W];
                sel_denom  = req_denom[idx*DENOM_W +: DENOM_W];
            end
        end
    end

    assign req_ready = rst ? '0 : grant;

    // The operand register carries its own tag so the tag pipe lines up with
    // the cycle the divider output becomes stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_W'(N_REQ - 1);
            div_numer  <= '0;
            div_denom  <= DENOM_W'(1);
            op_valid   <= 1'b0;
            op_id      <= '0;
            op_dbz     <= 1'b0;
        end else begin
            if (transfer) begin
                last_grant <= grant_id;
            end
            if (transfer && (sel_denom != '0)) begin
                div_numer <= sel_numer;
                div_denom <= sel_denom;
            end else begin
                div_numer <= '0;
                div_denom <= DENOM_W'(1);
            end
            op_valid <= transfer;
            op_id    <= grant_id;
            op_dbz   <= transfer && (sel_denom == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_dbz   <= '0;
            for (int s = 0; s < DIV_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= op_valid;
            tag_dbz[0]   <= op_dbz;
            tag_id[0]    <= op_id;
            for (int s = 1; s < DIV_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_dbz[s]   <= tag_dbz[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = tag_valid[LAST] && (tag_id[LAST] == ID_W'(i));
        end
        resp_quotient = tag_dbz[LAST] ? '0 : div_quotient;
        resp_dbz      = tag_valid[LAST] && tag_dbz[LAST];
        busy          = op_valid || (|tag_valid);
    end

endmodule
`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_div_share_arbiter : directed self-checking bench, 2- and 4-requester DUTs
// Revision 1.0
// ============================================================================
module tb_div_share_arbiter;

    localparam int DL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  v2;
    logic [47:0] numer2;
    logic [31:0] denom2;
    logic [1:0]  ready2;
    logic [23:0] div_n2;
    logic [15:0] div_d2;
    logic [23:0] div_q2;
    logic [1:0]  resp_v2;
    logic [23:0] resp_q2;
    logic        resp_z2;
    logic        busy2;

    logic [3:0]  v4;
    logic [95:0] numer4;
    logic [63:0] denom4;
    logic [3:0]  ready4;
    logic [23:0] div_n4;
    logic [15:0] div_d4;
    logic [23:0] div_q4;
    logic [3:0]  resp_v4;
    logic [23:0] resp_q4;
    logic        resp_z4;
    logic        busy4;

    div_share_arbiter #(.N_REQ(2), .NUMER_W(24), .DENOM_W(16), .DIV_LATENCY(DL)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_numer(numer2), .req_denom(denom2), .req_ready(ready2),
        .div_numer(div_n2), .div_denom(div_d2), .div_quotient(div_q2),
        .resp_valid(resp_v2), .resp_quotient(resp_q2), .resp_dbz(resp_z2), .busy(busy2)
    );

    div_share_arbiter #(.N_REQ(4), .NUMER_W(24), .DENOM_W(16), .DIV_LATENCY(DL)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(v4), .req_numer(numer4), .req_denom(denom4), .req_ready(ready4),
        .div_numer(div_n4), .div_denom(div_d4), .div_quotient(div_q4),
        .resp_valid(resp_v4), .resp_quotient(resp_q4), .resp_dbz(resp_z4), .busy(busy4)
    );

    // Pipelined divider models: quotient stable DL clocks after operand update
    logic [23:0] p2 [DL];
    logic [23:0] p4 [DL];
    always @(posedge clk) begin
        p2[0] <= (div_d2 != 0) ? div_n2 / 24'(div_d2) : 24'd0;
        p4[0] <= (div_d4 != 0) ? div_n4 / 24'(div_d4) : 24'd0;
        for (int k = 1; k < DL; k++) begin
            p2[k] <= p2[k-1];
            p4[k] <= p4[k-1];
        end
    end
    assign div_q2 = p2[DL-1];
    assign div_q4 = p4[DL-1];

    task automatic test_reset();
        rst = 1'b1; v2 = '0; numer2 = '0; denom2 = '0;
        v4 = '0; numer4 = '0; denom4 = '0;
        repeat (2) @(negedge clk);
        v2 = 2'b11; v4 = 4'b1111; #1;
        n_checks++; if (ready2 !== 2'b00) $display("FAIL rst_ready2 got %b want 00", ready2); else n_pass++;
        n_checks++; if (ready4 !== 4'b0000) $display("FAIL rst_ready4 got %b want 0000", ready4); else n_pass++;
        n_checks++; if (resp_v2 !== 2'b00) $display("FAIL rst_resp_valid got %b want 00", resp_v2); else n_pass++;
        n_checks++; if (resp_z2 !== 1'b0) $display("FAIL rst_resp_dbz got %b want 0", resp_z2); else n_pass++;
        n_checks++; if (busy2 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy2); else n_pass++;
        n_checks++; if (div_n2 !== 24'd0) $display("FAIL rst_div_numer got %0d want 0", div_n2); else n_pass++;
        n_checks++; if (div_d2 !== 16'd1) $display("FAIL rst_div_denom got %0d want 1", div_d2); else n_pass++;
        v2 = '0; v4 = '0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        numer2 = {24'd90, 24'd100};
        denom2 = {16'd3, 16'd4};
        for (int c = 0; c <= 21; c++) begin
            @(negedge clk);
            v2 = (c < 14) ? 2'b11 : 2'b00; #1;
            if (c < 14) begin
                n_checks++;
                if (ready2 !== ((c % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL cont_grant c=%0d got %b want %b", c, ready2, (c % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
            end
            if (c >= 7 && c <= 20) begin
                n_checks++;
                if (resp_v2 !== (((c - 7) % 2 == 0) ? 2'b01 : 2'b10))
                    $display("FAIL cont_resp_valid c=%0d got %b want %b", c, resp_v2, ((c - 7) % 2 == 0) ? 2'b01 : 2'b10);
                else n_pass++;
                n_checks++;
                if (resp_q2 !== (((c - 7) % 2 == 0) ? 24'd25 : 24'd30))
                    $display("FAIL cont_resp_q c=%0d got %0d want %0d", c, resp_q2, ((c - 7) % 2 == 0) ? 25 : 30);
                else n_pass++;
            end else begin
                n_checks++;
                if (resp_v2 !== 2'b00) $display("FAIL cont_idle c=%0d got %b want 00", c, resp_v2); else n_pass++;
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        numer2[23:0] = 24'd3200; denom2[15:0] = 16'd10; v2 = 2'b01; #1;
        n_checks++; if (ready2 !== 2'b01) $display("FAIL single_ready got %b want 01", ready2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00;
        n_checks++; if (div_n2 !== 24'd3200) $display("FAIL single_div_numer got %0d want 3200", div_n2); else n_pass++;
        n_checks++; if (div_d2 !== 16'd10) $display("FAIL single_div_denom got %0d want 10", div_d2); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k < 6) begin
                n_checks++; if (resp_v2 !== 2'b00) $display("FAIL single_early k=%0d got %b want 00", k, resp_v2); else n_pass++;
                n_checks++; if (busy2 !== 1'b1) $display("FAIL single_busy k=%0d got %b want 1", k, busy2); else n_pass++;
            end else if (k == 6) begin
                n_checks++; if (resp_v2 !== 2'b01) $display("FAIL single_resp_valid got %b want 01", resp_v2); else n_pass++;
                n_checks++; if (resp_q2 !== 24'd320) $display("FAIL single_resp_q got %0d want 320", resp_q2); else n_pass++;
                n_checks++; if (resp_z2 !== 1'b0) $display("FAIL single_resp_dbz got %b want 0", resp_z2); else n_pass++;
                n_checks++; if (busy2 !== 1'b1) $display("FAIL single_busy_last got %b want 1", busy2); else n_pass++;
            end else begin
                n_checks++; if (resp_v2 !== 2'b00) $display("FAIL single_pulse_len got %b want 00", resp_v2); else n_pass++;
                n_checks++; if (busy2 !== 1'b0) $display("FAIL single_busy_drop got %b want 0", busy2); else n_pass++;
            end
        end
    endtask

    task automatic test_div_by_zero();
        @(negedge clk);
        numer2 = {24'd500, 24'd0}; denom2 = {16'd0, 16'd1}; v2 = 2'b10; #1;
        n_checks++; if (ready2 !== 2'b10) $display("FAIL dbz_ready got %b want 10", ready2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00;
        n_checks++; if (div_n2 !== 24'd0) $display("FAIL dbz_div_numer got %0d want 0", div_n2); else n_pass++;
        n_checks++; if (div_d2 !== 16'd1) $display("FAIL dbz_div_denom got %0d want 1", div_d2); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                n_checks++; if (resp_v2 !== 2'b10) $display("FAIL dbz_resp_valid got %b want 10", resp_v2); else n_pass++;
                n_checks++; if (resp_q2 !== 24'd0) $display("FAIL dbz_resp_q got %0d want 0", resp_q2); else n_pass++;
                n_checks++; if (resp_z2 !== 1'b1) $display("FAIL dbz_flag got %b want 1", resp_z2); else n_pass++;
            end else begin
                n_checks++; if (resp_v2 !== 2'b00) $display("FAIL dbz_idle k=%0d got %b want 00", k, resp_v2); else n_pass++;
                n_checks++; if (resp_z2 !== 1'b0) $display("FAIL dbz_flag_idle k=%0d got %b want 0", k, resp_z2); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        denom2[15:0] = 16'd1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (c < 16) begin
                numer2[23:0] = 24'(c); v2 = 2'b01;
            end else begin
                v2 = 2'b00;
            end
            #1;
            if (c < 16) begin
                n_checks++; if (ready2 !== 2'b01) $display("FAIL b2b_ready c=%0d got %b want 01", c, ready2); else n_pass++;
            end
            if (c >= 7 && c <= 22) begin
                n_checks++; if (resp_v2 !== 2'b01) $display("FAIL b2b_resp_valid c=%0d got %b want 01", c, resp_v2); else n_pass++;
                n_checks++; if (resp_q2 !== 24'(c - 7)) $display("FAIL b2b_resp_q c=%0d got %0d want %0d", c, resp_q2, c - 7); else n_pass++;
            end else begin
                n_checks++; if (resp_v2 !== 2'b00) $display("FAIL b2b_idle c=%0d got %b want 00", c, resp_v2); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        denom2[15:0] = 16'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            numer2[23:0] = 24'(10 * (c + 1)); v2 = 2'b01;
        end
        @(negedge clk);
        v2 = 2'b00;
        @(negedge clk);
        rst = 1'b1; v2 = 2'b10; #1;
        n_checks++; if (ready2 !== 2'b00) $display("FAIL midrst_ready got %b want 00", ready2); else n_pass++;
        n_checks++; if (busy2 !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy2); else n_pass++;
        n_checks++; if (resp_v2 !== 2'b00) $display("FAIL midrst_resp got %b want 00", resp_v2); else n_pass++;
        n_checks++; if (div_n2 !== 24'd0) $display("FAIL midrst_div_numer got %0d want 0", div_n2); else n_pass++;
        n_checks++; if (div_d2 !== 16'd1) $display("FAIL midrst_div_denom got %0d want 1", div_d2); else n_pass++;
        @(negedge clk);
        rst = 1'b0; v2 = 2'b00;
        for (int k = 1; k <= DL + 2; k++) begin
            @(negedge clk);
            n_checks++; if (resp_v2 !== 2'b00) $display("FAIL midrst_late_resp k=%0d got %b want 00", k, resp_v2); else n_pass++;
        end
        @(negedge clk);
        numer2 = {24'd77, 24'd30}; denom2 = {16'd7, 16'd5}; v2 = 2'b11; #1;
        n_checks++; if (ready2 !== 2'b01) $display("FAIL midrst_first_grant got %b want 01", ready2); else n_pass++;
        @(negedge clk);
        v2 = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                n_checks++; if (resp_v2 !== 2'b01) $display("FAIL midrst_resp_valid got %b want 01", resp_v2); else n_pass++;
                n_checks++; if (resp_q2 !== 24'd6) $display("FAIL midrst_resp_q got %0d want 6", resp_q2); else n_pass++;
            end
        end
    endtask

    task automatic test_four_requesters();
        int exp_grant [8] = '{1, 3, 1, 3, 0, 1, 2, 3};
        numer4 = {4{24'd1200}};
        denom4 = {16'd4, 16'd3, 16'd2, 16'd1};
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            v4 = (c < 4) ? 4'b1010 : ((c < 8) ? 4'b1111 : 4'b0000); #1;
            if (c < 8) begin
                n_checks++;
                if (ready4 !== 4'(1 << exp_grant[c]))
                    $display("FAIL four_grant c=%0d got %b want %b", c, ready4, 4'(1 << exp_grant[c]));
                else n_pass++;
            end
            if (c >= 7 && c <= 14) begin
                n_checks++;
                if (resp_v4 !== 4'(1 << exp_grant[c-7]))
                    $display("FAIL four_resp_valid c=%0d got %b want %b", c, resp_v4, 4'(1 << exp_grant[c-7]));
                else n_pass++;
                n_checks++;
                if (resp_q4 !== 24'(1200 / (exp_grant[c-7] + 1)))
                    $display("FAIL four_resp_q c=%0d got %0d want %0d", c, resp_q4, 1200 / (exp_grant[c-7] + 1));
                else n_pass++;
            end else begin
                n_checks++; if (resp_v4 !== 4'b0000) $display("FAIL four_idle c=%0d got %b want 0000", c, resp_v4); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_four_requesters();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
